// File: rtl/build_info_uart_tx_if.sv
// Build-info dump bus: transmit request, the six build-info words,
// and the dump status / serial line.
interface build_info_uart_tx_if;
  logic        start_i;
  logic [63:0] git_hash_top;
  logic [31:0] timstamp_top;
  logic [63:0] git_hash_scripts;
  logic [31:0] timstamp_scripts;
  logic [63:0] git_hash_common;
  logic [31:0] timstamp_common;
  logic        busy_o;
  logic        done_o;
  logic        uart_tx_o;

  modport master (
    output start_i,
    output git_hash_top, timstamp_top,
    output git_hash_scripts, timstamp_scripts,
    output git_hash_common, timstamp_common,
    input  busy_o, done_o, uart_tx_o
  );

  modport slave (
    input  start_i,
    input  git_hash_top, timstamp_top,
    input  git_hash_scripts, timstamp_scripts,
    input  git_hash_common, timstamp_common,
    output busy_o, done_o, uart_tx_o
  );
endinterface

// File: rtl/build_info_uart_tx.sv
// Build-info UART dumper: snapshots the top/scripts/common git hashes and
// timestamps on request and sends them as three uppercase-hex text records
// ("T:<hash16> <ts8>\r\n", then S, then C) over an 8N1 serial line.
// Optional macro BUILD_INFO_AUTO_EN: one automatic dump shortly after reset.
module build_info_uart_tx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic                clk100,
  input  logic                rstn,
  build_info_uart_tx_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [6:0] CHAR_LAST = 7'd86;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("build_info_uart_tx: CLK_HZ/BAUD must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;
  logic [6:0]          char_cnt;
  logic [7:0]          shreg;
  logic                tx_q;
  logic                busy_q;
  logic                done_q;

  logic [63:0]         snap_hash_top;
  logic [31:0]         snap_ts_top;
  logic [63:0]         snap_hash_scripts;
  logic [31:0]         snap_ts_scripts;
  logic [63:0]         snap_hash_common;
  logic [31:0]         snap_ts_common;

  logic [6:0]          mux_idx;
  logic [1:0]          rec_sel;
  logic [4:0]          pos;
  logic [7:0]          rec_tag;
  logic [63:0]         rec_hash;
  logic [31:0]         rec_ts;
  logic [3:0]          hash_nib;
  logic [3:0]          ts_nib;
  logic [7:0]          char_mux;

  logic                start_req;
  logic                accept;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character generator: picks record and position from the character index.
  // In STOP the index looks one ahead so the next character is ready to load.
  always_comb begin
    mux_idx  = (state == ST_STOP) ? (char_cnt + 7'd1) : char_cnt;
    rec_sel  = 2'd0;
    pos      = 5'd0;
    rec_tag  = 8'h54;
    rec_hash = snap_hash_top;
    rec_ts   = snap_ts_top;
    char_mux = 8'h0A;

    if (mux_idx < 7'd29) begin
      rec_sel = 2'd0;
      pos     = 5'(mux_idx);
    end else if (mux_idx < 7'd58) begin
      rec_sel = 2'd1;
      pos     = 5'(mux_idx - 7'd29);
    end else begin
      rec_sel = 2'd2;
      pos     = 5'(mux_idx - 7'd58);
    end

    case (rec_sel)
      2'd0: begin
        rec_tag  = 8'h54;
        rec_hash = snap_hash_top;
        rec_ts   = snap_ts_top;
      end
      2'd1: begin
        rec_tag  = 8'h53;
        rec_hash = snap_hash_scripts;
        rec_ts   = snap_ts_scripts;
      end
      default: begin
        rec_tag  = 8'h43;
        rec_hash = snap_hash_common;
        rec_ts   = snap_ts_common;
      end
    endcase

    // Most-significant nibble first: hash digits at pos 2..17, timestamp at 19..26.
    hash_nib = rec_hash[{4'(5'd17 - pos), 2'b00} +: 4];
    ts_nib   = rec_ts[{3'(5'd26 - pos), 2'b00} +: 4];

    if (pos == 5'd0)       char_mux = rec_tag;
    else if (pos == 5'd1)  char_mux = 8'h3A;
    else if (pos <= 5'd17) char_mux = hex_ascii(hash_nib);
    else if (pos == 5'd18) char_mux = 8'h20;
    else if (pos <= 5'd26) char_mux = hex_ascii(ts_nib);
    else if (pos == 5'd27) char_mux = 8'h0D;
    else                   char_mux = 8'h0A;
  end

`ifdef BUILD_INFO_AUTO_EN
  logic [7:0] auto_cnt;
  logic       auto_pend;

  // Power-up delay counter and the one-shot automatic request it arms.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      auto_cnt  <= '0;
      auto_pend <= 1'b1;
    end else begin
      if (auto_cnt != 8'hFF) auto_cnt <= auto_cnt + 8'd1;
      if (accept) auto_pend <= 1'b0;
    end
  end

  assign start_req = bus.start_i | (auto_pend & (auto_cnt == 8'hFF));
`else
  assign start_req = bus.start_i;
`endif

  assign accept = (state == ST_IDLE) & start_req;

  // Dump FSM. Line and status outputs are registered from the current state,
  // so they trail the state by one clock; every bit period keeps its length.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state             <= ST_IDLE;
      baud_cnt          <= '0;
      bit_cnt           <= '0;
      char_cnt          <= '0;
      shreg             <= '0;
      tx_q              <= 1'b1;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      snap_hash_top     <= '0;
      snap_ts_top       <= '0;
      snap_hash_scripts <= '0;
      snap_ts_scripts   <= '0;
      snap_hash_common  <= '0;
      snap_ts_common    <= '0;
    end else begin
      tx_q   <= (state == ST_START) ? 1'b0 :
                (state == ST_DATA)  ? shreg[0] : 1'b1;
      busy_q <= (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
      done_q <= (state == ST_DONE);

      case (state)
        ST_IDLE: begin
          if (accept) begin
            snap_hash_top     <= bus.git_hash_top;
            snap_ts_top       <= bus.timstamp_top;
            snap_hash_scripts <= bus.git_hash_scripts;
            snap_ts_scripts   <= bus.timstamp_scripts;
            snap_hash_common  <= bus.git_hash_common;
            snap_ts_common    <= bus.timstamp_common;
            shreg             <= char_mux;
            char_cnt          <= '0;
            baud_cnt          <= '0;
            state             <= ST_START;
          end
        end

        ST_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) state   <= ST_STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (char_cnt == CHAR_LAST) begin
              char_cnt <= '0;
              state    <= ST_DONE;
            end else begin
              char_cnt <= char_cnt + 7'd1;
              shreg    <= char_mux;
              state    <= ST_START;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.uart_tx_o = tx_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_build_info_uart_tx.sv
// Directed bench for build_info_uart_tx at CLKS_PER_BIT=10 (default build).
module tb_build_info_uart_tx;

  logic clk100 = 1'b0;
  logic rstn;

  build_info_uart_tx_if bus ();

  build_info_uart_tx #(
    .CLK_HZ (1000),
    .BAUD   (100)
  ) dut (
    .clk100 (clk100),
    .rstn   (rstn),
    .bus    (bus.slave)
  );

  always #5 clk100 = ~clk100;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned busy_cnt = 0;

  always @(posedge clk100) cyc <= cyc + 1;

  always @(negedge clk100) begin
    if (bus.done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.busy_o === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receive one 8N1 character at 10 clocks/bit, sampling mid-bit on negedges.
  task automatic rx_char(input bit already_low, output logic [7:0] c);
    int unsigned n = 0;
    c = 8'h00;
    if (!already_low) begin
      @(negedge clk100);
      while (bus.uart_tx_o !== 1'b0 && n < 400) begin
        @(negedge clk100);
        n++;
      end
      check("rx_start_found", {127'd0, bus.uart_tx_o}, 128'd0);
      if (bus.uart_tx_o !== 1'b0) return;
    end
    repeat (15) @(negedge clk100);
    c[0] = bus.uart_tx_o;
    for (int b = 1; b < 8; b++) begin
      repeat (10) @(negedge clk100);
      c[b] = bus.uart_tx_o;
    end
    repeat (10) @(negedge clk100);
    check("stop_bit", {127'd0, bus.uart_tx_o}, 128'd1);
  endtask

  task automatic rx_dump(input string exp, input int first, input int last,
                         input bit first_low, input int pulse_at);
    logic [7:0] c;
    for (int i = first; i <= last; i++) begin
      if (i == pulse_at) begin
        bus.start_i = 1'b1;
        @(negedge clk100);
        bus.start_i = 1'b0;
      end
      rx_char(first_low && (i == first), c);
      check($sformatf("char%0d", i), {120'd0, c}, {120'd0, exp[i]});
    end
  endtask

  task automatic wait_done(input int unsigned start_cyc, input string tag);
    int unsigned n = 0;
    while (bus.done_o !== 1'b1 && n < 200) begin
      @(negedge clk100);
      n++;
    end
    check({tag, "_seen"}, {127'd0, bus.done_o}, 128'd1);
    check({tag, "_latency"}, 128'(cyc - start_cyc), 128'd8701);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned  sc;
    int unsigned  bb;
    bit           saw_low;
    logic [100:0] wave;
    logic [100:0] exp_wave;
    string        exp_a;
    string        exp_b;
    int           seg_vals [11] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    exp_a = {"T:0123456789ABCDEF DEADBEEF\015\012",
             "S:0000000000000000 00000000\015\012",
             "C:0000000000000000 00000000\015\012"};
    exp_b = {"T:FFFFFFFFFFFFFFFF DEADBEEF\015\012",
             "S:FEDCBA9876543210 13579BDF\015\012",
             "C:0F1E2D3C4B5A6978 CAFEF00D\015\012"};

    rstn                 = 1'b0;
    bus.start_i          = 1'b0;
    bus.git_hash_top     = 64'h0123456789ABCDEF;
    bus.timstamp_top     = 32'hDEADBEEF;
    bus.git_hash_scripts = 64'h0;
    bus.timstamp_scripts = 32'h0;
    bus.git_hash_common  = 64'h0;
    bus.timstamp_common  = 32'h0;

    repeat (3) @(negedge clk100);
    check("rst_tx",   {127'd0, bus.uart_tx_o}, 128'd1);
    check("rst_busy", {127'd0, bus.busy_o},    128'd0);
    check("rst_done", {127'd0, bus.done_o},    128'd0);
    rstn = 1'b1;

    saw_low = 1'b0;
    repeat (300) begin
      @(negedge clk100);
      if (bus.uart_tx_o !== 1'b1) saw_low = 1'b1;
    end
    check("idle_no_auto_dump", {127'd0, saw_low}, 128'd0);

    // Dump 1: frame timing, snapshot isolation, ignored mid-dump request.
    bus.start_i = 1'b1;
    #1 bb = busy_cnt;
    @(negedge clk100);
    bus.start_i      = 1'b0;
    bus.git_hash_top = 64'hFFFF_FFFF_FFFF_FFFF;
    sc = cyc;
    for (int k = 0; k < 20 && bus.uart_tx_o !== 1'b0; k++) @(negedge clk100);
    check("first_low_latency", 128'(cyc - sc), 128'd1);
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) @(negedge clk100);
      wave[k]     = bus.uart_tx_o;
      exp_wave[k] = (seg_vals[k / 10] != 0);
    end
    check("frame_T_timing", {27'd0, wave}, {27'd0, exp_wave});
    rx_dump(exp_a, 1, 86, 1'b1, 40);
    wait_done(sc, "dump1_done");
    #1;
    check("dump1_busy_cycles", 128'(busy_cnt - bb), 128'd8700);
    check("dump1_done_count",  128'(done_cnt),      128'd1);

    // Dump 2: requested on the edge right after the done pulse, new words.
    bus.git_hash_scripts = 64'hFEDCBA9876543210;
    bus.timstamp_scripts = 32'h13579BDF;
    bus.git_hash_common  = 64'h0F1E2D3C4B5A6978;
    bus.timstamp_common  = 32'hCAFEF00D;
    bus.start_i = 1'b1;
    bb = busy_cnt;
    @(negedge clk100);
    bus.start_i = 1'b0;
    sc = cyc;
    rx_dump(exp_b, 0, 86, 1'b0, -1);
    wait_done(sc, "dump2_done");
    #1;
    check("dump2_busy_cycles", 128'(busy_cnt - bb), 128'd8700);
    check("dump2_done_count",  128'(done_cnt),      128'd2);

    // Dump 3: reset asserted during character 10.
    @(negedge clk100);
    bus.start_i = 1'b1;
    @(negedge clk100);
    bus.start_i = 1'b0;
    rx_dump(exp_b, 0, 9, 1'b0, -1);
    repeat (50) @(negedge clk100);
    check("pre_reset_tx_low", {127'd0, bus.uart_tx_o}, 128'd0);
    rstn = 1'b0;
    #1;
    check("mid_reset_tx",   {127'd0, bus.uart_tx_o}, 128'd1);
    check("mid_reset_busy", {127'd0, bus.busy_o},    128'd0);
    check("mid_reset_done", {127'd0, bus.done_o},    128'd0);
    repeat (3) @(negedge clk100);
    rstn = 1'b1;
    saw_low = 1'b0;
    repeat (30) begin
      @(negedge clk100);
      if (bus.uart_tx_o !== 1'b1) saw_low = 1'b1;
    end
    #1;
    check("post_reset_quiet", {127'd0, saw_low}, 128'd0);
    check("reset_no_done",    128'(done_cnt),    128'd2);

    // Dump 4: full dump after the aborted one.
    @(negedge clk100);
    bus.start_i = 1'b1;
    #1 bb = busy_cnt;
    @(negedge clk100);
    bus.start_i = 1'b0;
    sc = cyc;
    rx_dump(exp_b, 0, 86, 1'b0, -1);
    wait_done(sc, "dump4_done");
    #1;
    check("dump4_busy_cycles", 128'(busy_cnt - bb), 128'd8700);
    check("dump4_done_count",  128'(done_cnt),      128'd3);

    saw_low = 1'b0;
    repeat (300) begin
      @(negedge clk100);
      if (bus.uart_tx_o !== 1'b1) saw_low = 1'b1;
    end
    check("final_idle", {127'd0, saw_low}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
